ram_slot_arbiter: RTL

Time-division arbiter for the shared 32 KB system RAM of the BBC micro core. It interleaves 6502 CPU accesses and video (CRTC/ULA) fetches in fixed alternating slots, producing the CPU and video clock enables from the 100 MHz system clock. An optional debug/loader port can borrow CPU slots. It sits between the CPU, the video fetch logic and the single-port block RAM inside TOP.

---
 rtl/ram_slot_arbiter_if.sv | 58 +++++
 rtl/ram_slot_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/ram_slot_arbiter_if.sv
// rtl/ram_slot_arbiter_if.sv - CPU/video/debug/RAM signal bundle for ram_slot_arbiter (debug signals only with ARB_DEBUG_PORT_EN)
interface ram_slot_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] CPU_ADDR;
    logic              CPU_WE;
    logic [DATA_W-1:0] CPU_WDATA;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              CPU_EN;

    logic [ADDR_W-1:0] VID_ADDR;
    logic [DATA_W-1:0] VID_RDATA;
    logic              VID_EN;

`ifdef ARB_DEBUG_PORT_EN
    logic              DBG_REQ;
    logic              DBG_WE;
    logic [ADDR_W-1:0] DBG_ADDR;
    logic [DATA_W-1:0] DBG_WDATA;
    logic [DATA_W-1:0] DBG_RDATA;
    logic              DBG_ACK;
`endif

    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WE;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;

    // slave is the arbiter; master is everything around it, including the RAM
`ifdef ARB_DEBUG_PORT_EN
    modport slave (
        input  CPU_ADDR, CPU_WE, CPU_WDATA, VID_ADDR, RAM_RDATA,
        input  DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
        output CPU_RDATA, CPU_EN, VID_RDATA, VID_EN,
        output DBG_RDATA, DBG_ACK,
        output RAM_ADDR, RAM_WE, RAM_WDATA
    );
    modport master (
        output CPU_ADDR, CPU_WE, CPU_WDATA, VID_ADDR, RAM_RDATA,
        output DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
        input  CPU_RDATA, CPU_EN, VID_RDATA, VID_EN,
        input  DBG_RDATA, DBG_ACK,
        input  RAM_ADDR, RAM_WE, RAM_WDATA
    );
`else
    modport slave (
        input  CPU_ADDR, CPU_WE, CPU_WDATA, VID_ADDR, RAM_RDATA,
        output CPU_RDATA, CPU_EN, VID_RDATA, VID_EN,
        output RAM_ADDR, RAM_WE, RAM_WDATA
    );
    modport master (
        output CPU_ADDR, CPU_WE, CPU_WDATA, VID_ADDR, RAM_RDATA,
        input  CPU_RDATA, CPU_EN, VID_RDATA, VID_EN,
        input  RAM_ADDR, RAM_WE, RAM_WDATA
    );
`endif
endinterface

// File: rtl/ram_slot_arbiter.sv
// rtl/ram_slot_arbiter.sv - Time-division video/CPU slot arbiter for the shared system RAM; debug slot stealing with ARB_DEBUG_PORT_EN
module ram_slot_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int SLOT_LEN = 25
) (
    input  logic               CLK100MHZ,
    input  logic               RESET,
    ram_slot_arbiter_if.slave  bus
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(SLOT_LEN - 2);

`ifdef ARB_DEBUG_PORT_EN
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_DBG} owner_t;
    logic prev_dbg;
`else
    typedef enum logic {OWN_VID, OWN_CPU} owner_t;
`endif

    logic [CNT_W-1:0]  cnt;
    logic              phase;
    owner_t            owner;

    owner_t            next_owner;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic              next_we;

    // Owner selection, only consumed at cnt=0 of a slot
    always_comb begin
        next_owner = OWN_VID;
        next_addr  = bus.VID_ADDR;
        next_wdata = '0;
        next_we    = 1'b0;
        if (phase) begin
            next_owner = OWN_CPU;
            next_addr  = bus.CPU_ADDR;
            next_wdata = bus.CPU_WDATA;
            next_we    = bus.CPU_WE;
`ifdef ARB_DEBUG_PORT_EN
            if (bus.DBG_REQ && !prev_dbg) begin
                next_owner = OWN_DBG;
                next_addr  = bus.DBG_ADDR;
                next_wdata = bus.DBG_WDATA;
                next_we    = bus.DBG_WE;
            end
`endif
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            cnt           <= '0;
            phase         <= 1'b0;
            owner         <= OWN_VID;
            bus.RAM_ADDR  <= '0;
            bus.RAM_WDATA <= '0;
            bus.RAM_WE    <= 1'b0;
            bus.CPU_RDATA <= '0;
            bus.CPU_EN    <= 1'b0;
            bus.VID_RDATA <= '0;
            bus.VID_EN    <= 1'b0;
`ifdef ARB_DEBUG_PORT_EN
            prev_dbg      <= 1'b0;
            bus.DBG_RDATA <= '0;
            bus.DBG_ACK   <= 1'b0;
`endif
        end else begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            bus.RAM_WE <= 1'b0;
            bus.CPU_EN <= 1'b0;
            bus.VID_EN <= 1'b0;
`ifdef ARB_DEBUG_PORT_EN
            bus.DBG_ACK <= 1'b0;
`endif

            // Address and data are held for the slot; the write strobe lasts only cnt=1
            if (cnt == '0) begin
                owner         <= next_owner;
                bus.RAM_ADDR  <= next_addr;
                bus.RAM_WDATA <= next_wdata;
                bus.RAM_WE    <= next_we;
`ifdef ARB_DEBUG_PORT_EN
                if (phase)
                    prev_dbg <= (next_owner == OWN_DBG);
`endif
            end

            if (cnt == CNT_LATCH) begin
                case (owner)
                    OWN_VID: begin
                        bus.VID_RDATA <= bus.RAM_RDATA;
                        bus.VID_EN    <= 1'b1;
                    end
                    OWN_CPU: begin
                        bus.CPU_RDATA <= bus.RAM_RDATA;
                        bus.CPU_EN    <= 1'b1;
                    end
`ifdef ARB_DEBUG_PORT_EN
                    OWN_DBG: begin
                        bus.DBG_RDATA <= bus.RAM_RDATA;
                        bus.DBG_ACK   <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
